// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between I-cache block reads and
// D-cache block reads / single-word writes, granting one whole transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_data_valid,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     i_grant,
  output logic                     d_grant,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     i_data_valid,
  output logic                     d_data_valid,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_done,
  output logic                     d_done
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] ISS_END  = CNT_W'(WORDS);
  localparam logic [IDX_W-1:0] RET_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  iss_cnt, iss_cnt_nxt;
  logic [IDX_W-1:0]  ret_cnt, ret_cnt_nxt;
  logic [ADDR_W-1:0] base;
  logic              last_d, last_d_nxt;
  logic              pick_i, pick_d;

  // Block base: byte address with the word-in-block and byte-in-word bits cleared.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'((1 << (IDX_W + 1)) - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [CNT_W-1:0]  n);
    return b + ADDR_W'({n, 1'b0});
  endfunction

  // On a tie the requester that did not own the last transaction wins.
  assign pick_d = d_req && (!i_req || !last_d);
  assign pick_i = i_req && !pick_d;

  assign fill_data = mem_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      iss_cnt <= '0;
      ret_cnt <= '0;
      last_d  <= 1'b0;
    end else begin
      state   <= state_nxt;
      iss_cnt <= iss_cnt_nxt;
      ret_cnt <= ret_cnt_nxt;
      last_d  <= last_d_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) base <= block_base(pick_d ? d_addr : i_addr);
  end

  always_comb begin
    state_nxt    = state;
    iss_cnt_nxt  = iss_cnt;
    ret_cnt_nxt  = ret_cnt;
    last_d_nxt   = last_d;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    fill_word    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    case (state)
      IDLE: begin
        iss_cnt_nxt = '0;
        ret_cnt_nxt = '0;
        if (pick_d)      state_nxt = d_wr ? D_WR : D_RD;
        else if (pick_i) state_nxt = I_RD;
      end
      I_RD, D_RD: begin
        i_grant = (state == I_RD);
        d_grant = (state == D_RD);
        if (iss_cnt < ISS_END) begin
          mem_en      = 1'b1;
          mem_addr    = word_addr(base, iss_cnt);
          iss_cnt_nxt = iss_cnt + CNT_W'(1);
        end
        if (mem_data_valid) begin
          i_data_valid = i_grant;
          d_data_valid = d_grant;
          fill_word    = ret_cnt;
          ret_cnt_nxt  = ret_cnt + IDX_W'(1);
          if (ret_cnt == RET_LAST) begin
            i_done     = i_grant;
            d_done     = d_grant;
            last_d_nxt = d_grant;
            state_nxt  = IDLE;
          end
        end
      end
      D_WR: begin
        d_grant    = 1'b1;
        mem_en     = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
        d_done     = 1'b1;
        last_d_nxt = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus a pipelined memory
// responder; directed vector table, corner-case sequences and randomized traffic.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_data = '0;
  logic        mem_data_valid = 1'b0;
  logic        mem_en, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_grant(i_grant), .d_grant(d_grant), .fill_data(fill_data), .i_data_valid(i_data_valid),
    .d_data_valid(d_data_valid), .fill_word(fill_word), .i_done(i_done), .d_done(d_done));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Memory responder state
  typedef struct { int due; logic [15:0] addr; } ret_t;
  ret_t pend[$];
  int   lat = 4;
  bit   gap_mode = 0;
  bit   force_valid = 0;

  // Reference model state (owner: 0 none, 1 I, 2 D)
  int          m_owner = 0, m_last = 1, m_issued = 0, m_ret = 0;
  bit          m_wr = 0;
  logic [15:0] m_base = '0;
  bit          prev_idle = 1, prev_done = 0, prev_i = 0, prev_d = 0, prev_dwr = 0;
  logic [15:0] prev_iaddr = '0, prev_daddr = '0;

  // Observation latches used by the stimulus
  bit          seen_idone = 0, seen_ddone = 0, seen_igrant = 0;
  int          ivld_seen = 0, n_new = 0, first_own = 0, second_own = 0;
  logic [15:0] first_addr = '0;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic observe();
    int cur, exp_own;
    bit e_en, e_wr, e_iv, e_dv, e_id, e_dd;
    logic [15:0] e_addr, e_wdata;
    chk("fill_data_pass", fill_data, mem_data);
    if (!rst) begin
      chk("rst_ctrl", {mem_en, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_word", fill_word, 0);
      m_owner = 0; m_last = 1; prev_idle = 1; prev_done = 0; prev_i = 0; prev_d = 0;
      pend.delete();
      cyc++;
      return;
    end
    cur = i_grant ? 1 : (d_grant ? 2 : 0);
    chk("one_grant", i_grant & d_grant, 0);
    chk("ivld_needs_grant", i_data_valid & ~i_grant, 0);
    chk("dvld_needs_grant", d_data_valid & ~d_grant, 0);
    if (prev_idle) begin
      if (prev_i && prev_d) exp_own = (m_last == 1) ? 2 : 1;
      else if (prev_d)      exp_own = 2;
      else if (prev_i)      exp_own = 1;
      else                  exp_own = 0;
    end else begin
      exp_own = prev_done ? 0 : m_owner;
    end
    chk("owner", cur, exp_own);
    if (prev_idle && exp_own != 0) begin
      m_owner = exp_own;
      m_wr = (exp_own == 2) && prev_dwr;
      m_base = ((exp_own == 1) ? prev_iaddr : prev_daddr) & BLK_MASK;
      m_issued = 0;
      m_ret = 0;
      n_new++;
      if (n_new == 1) begin first_own = exp_own; first_addr = mem_addr; end
      else if (n_new == 2) second_own = exp_own;
    end else if (exp_own == 0) begin
      m_owner = 0;
    end
    e_en = 0; e_wr = 0; e_iv = 0; e_dv = 0; e_id = 0; e_dd = 0; e_addr = '0; e_wdata = '0;
    if (m_owner != 0 && m_wr) begin
      e_en = 1; e_wr = 1; e_addr = d_addr; e_wdata = d_wdata; e_dd = 1;
    end else if (m_owner != 0) begin
      if (m_issued < WORDS) begin e_en = 1; e_addr = m_base + 16'(2 * m_issued); end
      if (mem_data_valid) begin
        if (m_owner == 1) e_iv = 1; else e_dv = 1;
        if (m_ret == WORDS - 1) begin
          if (m_owner == 1) e_id = 1; else e_dd = 1;
        end
      end
    end
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
      else m_issued++;
    end
    if (mem_en && !mem_wr) pend.push_back('{cyc + lat, mem_addr});
    chk("i_data_valid", i_data_valid, e_iv);
    chk("d_data_valid", d_data_valid, e_dv);
    chk("i_done", i_done, e_id);
    chk("d_done", d_done, e_dd);
    if (e_iv || e_dv) begin
      chk("fill_word", fill_word, m_ret);
      chk("fill_data", fill_data, mdata(m_base + 16'(2 * m_ret)));
      m_ret++;
    end
    if (e_id || e_dd) m_last = m_owner;
    if (i_done) seen_idone = 1;
    if (d_done) seen_ddone = 1;
    if (i_grant) seen_igrant = 1;
    if (i_data_valid) ivld_seen++;
    prev_done = e_id || e_dd;
    prev_idle = (exp_own == 0);
    prev_i = i_req; prev_d = d_req; prev_dwr = d_wr;
    prev_iaddr = i_addr; prev_daddr = d_addr;
    cyc++;
  endtask

  task automatic drive_mem();
    mem_data_valid = 1'b0;
    mem_data = 16'($urandom);
    if (force_valid) begin
      mem_data_valid = 1'b1;
      force_valid = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc && (!gap_mode || $urandom_range(0, 2) == 0)) begin
      mem_data = mdata(pend[0].addr);
      void'(pend.pop_front());
      mem_data_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic clear_seen();
    seen_idone = 0; seen_ddone = 0; seen_igrant = 0;
    ivld_seen = 0; n_new = 0; first_own = 0; second_own = 0; first_addr = '0;
  endtask

  typedef struct {
    logic i, d, dwr;
    logic [15:0] ia, da, wd, faddr;
    int first, second;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h1236, 16'h4000, 16'h0000, 16'h4000, 2, 1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h2222, 16'h400A, 16'h0000, 16'h4000, 2, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h1236, 16'h0000, 16'h0000, 16'h1230, 1, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h2005, 16'hBEEF, 16'h2005, 2, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0104, 16'h7FFF, 16'h1234, 16'h0100, 1, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'hABCD, 16'h5555, 16'h0000, 16'hABC0, 1, 2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFF0, 2, 0};

    repeat (3) tick();
    rst = 1'b1;
    tick();

    foreach (vecs[v]) begin
      clear_seen();
      i_addr = vecs[v].ia; d_addr = vecs[v].da; d_wr = vecs[v].dwr; d_wdata = vecs[v].wd;
      i_req = vecs[v].i; d_req = vecs[v].d;
      for (k = 0; k < 200; k++) begin
        tick();
        if (seen_idone) i_req = 1'b0;
        if (seen_ddone) d_req = 1'b0;
        if (!i_req && !d_req) break;
      end
      if (k == 200) chk("vec_timeout", 0, 1);
      chk("vec_first_owner", first_own, vecs[v].first);
      chk("vec_first_addr", first_addr, vecs[v].faddr);
      chk("vec_second_owner", second_own, vecs[v].second);
      repeat (2) tick();
    end

    // Gapped returns on a D block read
    clear_seen();
    gap_mode = 1; d_wr = 1'b0; d_addr = 16'h3016; d_req = 1'b1;
    for (k = 0; k < 400 && !seen_ddone; k++) tick();
    d_req = 1'b0; gap_mode = 0;
    chk("gap_d_done", seen_ddone, 1);
    repeat (3) tick();

    // Reset after the third returned word of an I read
    clear_seen();
    lat = 4; i_addr = 16'h1236; i_req = 1'b1;
    for (k = 0; k < 100 && ivld_seen < 3; k++) tick();
    chk("rst_mid_reached", ivld_seen, 3);
    rst = 1'b0; i_req = 1'b0;
    #1;
    chk("async_rst_grant", {i_grant, d_grant, mem_en, i_data_valid}, 0);
    tick();
    rst = 1'b1; force_valid = 1;
    ivld_seen = 0;
    tick();
    tick();
    chk("stray_valid_ignored", ivld_seen, 0);
    clear_seen();
    i_addr = 16'h0040; i_req = 1'b1;
    for (k = 0; k < 100 && !seen_idone; k++) tick();
    i_req = 1'b0;
    chk("after_rst_done", seen_idone, 1);
    chk("after_rst_words", ivld_seen, WORDS);
    repeat (2) tick();

    // Request dropped right after grant, top-of-memory block
    clear_seen();
    i_addr = 16'hFFF7; i_req = 1'b1;
    for (k = 0; k < 100 && !seen_idone; k++) begin
      tick();
      if (seen_igrant) i_req = 1'b0;
    end
    chk("drop_done", seen_idone, 1);
    chk("drop_words", ivld_seen, WORDS);
    repeat (2) tick();

    // Randomized traffic, two phases: short latency without gaps, long latency with gaps
    for (int ph = 0; ph < 2; ph++) begin
      lat = (ph == 0) ? 1 : 6;
      gap_mode = (ph == 1);
      clear_seen();
      for (int c = 0; c < 400; c++) begin
        tick();
        if (seen_idone) begin i_req = 1'b0; seen_idone = 0; end
        else if (!i_req && $urandom_range(0, 3) == 0) begin
          i_addr = 16'($urandom); i_req = 1'b1;
        end
        if (seen_ddone) begin d_req = 1'b0; seen_ddone = 0; end
        else if (!d_req && $urandom_range(0, 3) == 0) begin
          d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = $urandom_range(0, 2) == 0;
          d_req = 1'b1;
        end
      end
      for (k = 0; k < 300 && (i_req || d_req); k++) begin
        tick();
        if (seen_idone) begin i_req = 1'b0; seen_idone = 0; end
        if (seen_ddone) begin d_req = 1'b0; seen_ddone = 0; end
      end
      chk("random_drain", {i_req, d_req}, 0);
      repeat (3) tick();
    end
    gap_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single pipelined main-memory port between the I-cache fill path and the D-cache fill/store path.
- Grants the port to one requester for a whole transaction:
  - 8-word block read: the arbiter sequences all block word addresses itself.
  - Single-word write: one cycle.
- Routes returned words back with a word index and a done pulse.
- Sits between both cache fill FSMs and the memory model.

Parameters:
- ADDR_W, 16, address width (byte address).
- DATA_W, 16, memory word width.
- WORDS, 8, words per cache block (power of 2); block offset bits = log2(WORDS)+1.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache block-read request; held until i_done.
- i_addr  in  ADDR_W  I-cache miss address.
- d_req  in  1  D-cache request; held until d_done.
- d_wr  in  1  1 = single-word write, 0 = block read; sampled at grant.
- d_addr  in  ADDR_W  D-cache miss or store address.
- d_wdata  in  DATA_W  store data.
- mem_data  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_data valid this cycle.
- mem_en  out  1  memory access issued this cycle.
- mem_wr  out  1  issued access is a write.
- mem_addr  out  ADDR_W  issued address.
- mem_wdata  out  DATA_W  write data.
- i_grant  out  1  port owned by I-cache.
- d_grant  out  1  port owned by D-cache.
- fill_data  out  DATA_W  mem_data passthrough.
- i_data_valid  out  1  fill word for I-cache this cycle.
- d_data_valid  out  1  fill word for D-cache this cycle.
- fill_word  out  log2(WORDS)  index of the current fill word.
- i_done  out  1  one-cycle pulse, I transaction complete.
- d_done  out  1  one-cycle pulse, D transaction complete.

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR. Registers: state, iss_cnt (0..WORDS), ret_cnt (0..WORDS-1), base address, last_grant.
- Reset (rst=0, async):
  - state=IDLE; iss_cnt=ret_cnt=0; last_grant=I.
  - Every output 0: grants, mem_en, mem_wr, valids, dones, fill_word, mem_addr, mem_wdata.
  - fill_data follows mem_data.
- IDLE:
  - Requests are sampled; the grant state is entered on the next edge (1-cycle grant latency).
  - Only one requester: grant it.
  - Both requesters: grant the one not equal to last_grant, so D wins first after reset.
  - At grant: base = addr with the low log2(WORDS)+1 bits cleared; d_wr is captured into the state choice; iss_cnt and ret_cnt cleared.
  - mem_data_valid is ignored in IDLE (no forwarding).
- I_RD / D_RD:
  - Grant held high for the whole state.
  - While iss_cnt<WORDS: mem_en=1, mem_wr=0, mem_addr = base + 2*iss_cnt, iss_cnt++.
  - Issue is one address per cycle, so WORDS consecutive issue cycles.
  - Each mem_data_valid:
    - Owner's data_valid=1, fill_word=ret_cnt, ret_cnt++.
    - Returns may overlap issue and may have gaps.
  - When mem_data_valid and ret_cnt==WORDS-1: owner's done=1, last_grant=owner, next state IDLE.
- D_WR:
  - Lasts exactly one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr (unaligned, not the block base), mem_wdata=d_wdata.
  - d_done=1; last_grant=D; next state IDLE.
- Request drop: a request deasserted mid-transaction is ignored; the transaction completes.
- Back-to-back: at least one IDLE cycle between a done and the next grant.
- Address arithmetic: mod 2^ADDR_W.
- Reset mid-transaction: abort immediately, return to IDLE. Late mem_data_valid after reset is ignored.
- Outputs are decoded combinationally from the registered state and counters.
- Invariants:
  - Never both grants high.
  - Never a data_valid without its grant.

Test Plan:
- I-only read, i_addr=0x1236, memory latency 4 -> i_grant 1 cycle later; mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles; 8 i_data_valid with fill_word 0..7; i_done with word 7; then IDLE.
- i_req and d_req both rise in the same cycle after reset, d_wr=0, d_addr=0x4000 -> D granted first (0x4000..0x400E). After d_done + 1 IDLE cycle, I granted. A new simultaneous request then goes to D again (alternation).
- D write, d_addr=0x2005, d_wdata=0xBEEF -> one cycle with mem_en=1, mem_wr=1, mem_addr=0x2005, mem_wdata=0xBEEF, d_done=1; no d_data_valid.
- D read with valids gapped (valid, gap, gap, …) -> fill_word increments only on valid; d_done only with the 8th valid; no extra mem_en after 8 issues.
- rst low after 3rd returned word of an I read -> all outputs 0 immediately; stray mem_data_valid next cycle produces no i_data_valid; new i_req is served from word 0.
- i_req deasserted after grant, address block 0xFFF0 -> burst still completes, addresses 0xFFF0..0xFFFE with no carry errors; i_done asserted.
